// File: rtl/mem_pkg.sv
// Shared memory-access definitions for the processor data port and the data cache:
// access-size codes, controller state encoding and big-endian lane order.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte offset 0 lives in bits 31:24, so its enable is the MSB of byteen.
    localparam logic [3:0] BE_LANE0 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-cache request/response bus between the processor-side initiator (master)
// and the data cache (slave).
interface dmem_access_ctrl_if;

    logic        memwrite;
    logic        memread;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [3:0]  byteen;
    logic [31:0] readdata;
    logic        dataack;

    modport master (
        output memwrite, memread, dataadr, writedata, byteen,
        input  readdata, dataack
    );

    modport slave (
        input  memwrite, memread, dataadr, writedata, byteen,
        output readdata, dataack
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane logic: byte enables and replicated store data
// from size/offset, plus extraction and extension of a load from the cache word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byteen,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rdata[31 - 8*gi -: 8];
        end
    endgenerate

    assign w_byte = w_lane[i_offset];
    assign w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];

    // Size code 11 falls through to the word case.
    always_comb begin
        o_byteen = 4'b1111;
        o_wdata  = i_wdata;
        o_rdata  = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_byteen = BE_LANE0 >> i_offset;
                o_wdata  = {4{i_wdata[7:0]}};
                o_rdata  = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_byteen = i_offset[1] ? 4'b0011 : 4'b1100;
                o_wdata  = {2{i_wdata[15:0]}};
                o_rdata  = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Processor-side data-cache initiator: turns one memory-stage load/store into a
// held cache request, stalls until ack or timeout, then returns aligned load data.
module dmem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [1:0]                 req_size,
    input  logic                       req_signed,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       stall,
    output logic                       done,
    output logic [31:0]                loaddata,
    output logic                       misaligned,
    output logic                       buserr,
    dmem_access_ctrl_if.master         bus
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t      r_state;
    state_t      w_state_next;
    logic [CW-1:0] r_cnt;
    logic        r_memwrite;
    logic        r_memread;
    logic [31:0] r_dataadr;
    logic [31:0] r_writedata;
    logic [3:0]  r_byteen;
    logic [1:0]  r_size;
    logic [1:0]  r_offset;
    logic        r_signed;
    logic [31:0] r_loaddata;

    logic        w_accept;
    logic        w_cnt_hit;
    logic [1:0]  w_sel_size;
    logic [1:0]  w_sel_offset;
    logic        w_sel_signed;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;

    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign w_accept   = (r_state == IDLE) && req_valid && !misaligned;
    assign w_cnt_hit  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // One aligner serves both directions: request fields while idle, captured fields while busy.
    assign w_sel_size   = (r_state == IDLE) ? req_size        : r_size;
    assign w_sel_offset = (r_state == IDLE) ? req_addr[1:0]   : r_offset;
    assign w_sel_signed = (r_state == IDLE) ? req_signed      : r_signed;

    mem_lane_align u_align (
        .i_size   (w_sel_size),
        .i_offset (w_sel_offset),
        .i_signed (w_sel_signed),
        .i_wdata  (req_wdata),
        .i_rdata  (bus.readdata),
        .o_byteen (w_byteen),
        .o_wdata  (w_wdata_rep),
        .o_rdata  (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        done         = 1'b0;
        buserr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    stall        = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.dataack) begin
                    w_state_next = DONE;
                end else if (w_cnt_hit) begin
                    buserr       = 1'b1;
                    stall        = 1'b0;
                    w_state_next = IDLE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_memwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_dataadr   <= '0;
            r_writedata <= '0;
            r_byteen    <= '0;
            r_size      <= SZ_BYTE;
            r_offset    <= 2'b00;
            r_signed    <= 1'b0;
            r_loaddata  <= '0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_memwrite  <= req_write;
            r_memread   <= !req_write;
            r_dataadr   <= {req_addr[31:2], 2'b00};
            r_writedata <= w_wdata_rep;
            r_byteen    <= w_byteen;
            r_size      <= req_size;
            r_offset    <= req_addr[1:0];
            r_signed    <= req_signed;
        end else if (r_state == BUSY) begin
            if (bus.dataack) begin
                r_loaddata <= w_rdata_ext;
                r_memwrite <= 1'b0;
                r_memread  <= 1'b0;
            end else if (w_cnt_hit) begin
                r_memwrite <= 1'b0;
                r_memread  <= 1'b0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign loaddata      = r_loaddata;
    assign bus.memwrite  = r_memwrite;
    assign bus.memread   = r_memread;
    assign bus.dataadr   = r_dataadr;
    assign bus.writedata = r_writedata;
    assign bus.byteen    = r_byteen;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases followed by random
// loads/stores compared against an arithmetic reference of the access rules.
module tb_dmem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] loaddata;
    logic        misaligned;
    logic        buserr;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .loaddata   (loaddata),
        .misaligned (misaligned),
        .buserr     (buserr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on byte offsets, big-endian lane order.
    function automatic logic model_mis(input logic [1:0] sz, input logic [1:0] o);
        int oi = int'(o);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (oi % 2) != 0;
        return oi != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] o);
        int oi = int'(o);
        if (sz == 2'd0) return 4'(1 << (3 - oi));
        if (sz == 2'd1) return 4'(3 << (2 - oi));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_ld(input logic [1:0] sz, input logic [1:0] o,
                                             input logic sg, input logic [31:0] r);
        int oi = int'(o);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (r >> (8 * (3 - oi))) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (r >> (8 * (2 - oi))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    // ack = cycle (>=1) in which dataack is raised; 0 or > TMO means the access times out.
    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack);
        logic mis;
        logic tmo_now;
        mis = model_mis(sz, ad[1:0]);
        txn++;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd; bus.dataack = 1'b0; bus.readdata = $urandom;
        #3;
        chk("c0_stall", 32'(stall), 32'(!mis));
        chk("c0_misaligned", 32'(misaligned), 32'(mis));
        chk("c0_done", 32'(done), 32'd0);
        chk("c0_buserr", 32'(buserr), 32'd0);
        if (mis) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            #3;
            chk("mis_memwrite", 32'(bus.memwrite), 32'd0);
            chk("mis_memread", 32'(bus.memread), 32'd0);
            chk("mis_stall", 32'(stall), 32'd0);
            $display("txn %0d wr=%0d sz=%0d addr=%h misaligned, no access", txn, wr, sz, ad);
            return;
        end
        for (int c = 1; c <= TMO; c++) begin
            @(posedge clk); #1;
            bus.dataack  = (c == ack);
            bus.readdata = (c == ack) ? rd : $urandom;
            tmo_now = (c == TMO) && (ack != c);
            #3;
            chk("busy_memwrite", 32'(bus.memwrite), 32'(wr));
            chk("busy_memread", 32'(bus.memread), 32'(!wr));
            chk("busy_dataadr", bus.dataadr, ad & 32'hFFFF_FFFC);
            chk("busy_byteen", 32'(bus.byteen), 32'(model_be(sz, ad[1:0])));
            if (wr) chk("busy_writedata", bus.writedata, model_wd(sz, wd));
            chk("busy_stall", 32'(stall), 32'(!tmo_now));
            chk("busy_buserr", 32'(buserr), 32'(tmo_now));
            chk("busy_done", 32'(done), 32'd0);
            if (c == ack) begin
                @(posedge clk); #1;
                bus.dataack = 1'b0;
                bus.readdata = $urandom;
                #3;
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_stall", 32'(stall), 32'd0);
                chk("done_memwrite", 32'(bus.memwrite), 32'd0);
                chk("done_memread", 32'(bus.memread), 32'd0);
                chk("done_buserr", 32'(buserr), 32'd0);
                if (!wr) chk("done_loaddata", loaddata, model_ld(sz, ad[1:0], sg, rd));
                $display("txn %0d wr=%0d sz=%0d sg=%0d addr=%h ack@%0d loaddata=%h done",
                         txn, wr, sz, sg, ad, ack, loaddata);
                return;
            end
            if (tmo_now) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                bus.dataack = 1'b0;
                #3;
                chk("tmo_memwrite", 32'(bus.memwrite), 32'd0);
                chk("tmo_memread", 32'(bus.memread), 32'd0);
                chk("tmo_stall", 32'(stall), 32'd0);
                chk("tmo_done", 32'(done), 32'd0);
                $display("txn %0d wr=%0d sz=%0d addr=%h timeout buserr", txn, wr, sz, ad);
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        bus.dataack = 1'b0; bus.readdata = '0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_buserr", 32'(buserr), 32'd0);
        chk("rst_memwrite", 32'(bus.memwrite), 32'd0);
        chk("rst_memread", 32'(bus.memread), 32'd0);
        chk("rst_dataadr", bus.dataadr, 32'd0);
        chk("rst_writedata", bus.writedata, 32'd0);
        chk("rst_byteen", 32'(bus.byteen), 32'd0);
        chk("rst_loaddata", loaddata, 32'd0);
        $display("txn 0 reset values checked");
        @(posedge clk); #1;
        reset = 1'b0;

        access(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1);
        access(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1);
        access(1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, 32'h12F4_5678, 1);
        access(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'h12F4_5678, 2);
        access(1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 3);
        access(1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h0, 32'h0, 1);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 0);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, TMO);
        access(1'b1, 2'd3, 1'b0, 32'h0000_0308, 32'h1234_5678, 32'h0, 2);

        // Reset in the middle of a busy access; an ack arriving while idle is ignored.
        txn++;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h0000_0400; bus.dataack = 1'b0;
        #3; chk("rstb_c0_stall", 32'(stall), 32'd1);
        @(posedge clk); #4;
        chk("rstb_c1_memread", 32'(bus.memread), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #3; chk("rstb_c2_memread", 32'(bus.memread), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; bus.dataack = 1'b1; bus.readdata = 32'h5555_AAAA;
        #3;
        chk("rstb_c3_memread", 32'(bus.memread), 32'd0);
        chk("rstb_c3_memwrite", 32'(bus.memwrite), 32'd0);
        chk("rstb_c3_stall", 32'(stall), 32'd0);
        chk("rstb_c3_done", 32'(done), 32'd0);
        chk("rstb_c3_loaddata", loaddata, 32'd0);
        $display("txn %0d reset during busy, access dropped", txn);
        access(1'b0, 2'd0, 1'b0, 32'h0000_0402, 32'h0, 32'hA1B2_C3D4, 1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (a[1:0] & 2'b10);
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, $urandom, $urandom_range(1, TMO + 1));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
        end

        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
